// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
//   state_t    : scan FSM states
//   SSEG_BLANK : all segments off (active-low)
//   idx_w()    : digit index width, never below 1
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] SSEG_BLANK = 8'hFF;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_hex2sseg.sv
// Hex nibble to seven-segment decoder, common anode (active-low).
//   hex_i : nibble 0..F
//   seg_o : {g,f,e,d,c,b,a}, 0 = segment lit
module hex2sseg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    unique case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode display.
// One decoder is shared; each digit gets 2**REFRESH_BITS lit cycles then a
// single blank anti-ghosting cycle. Data passes staging -> shadow only at
// frame boundaries (or while idle) so a frame never shows mixed data.
// Optional: define SSEG_LZ_BLANK_EN for leading-zero blanking.
// Ports:
//   clk, reset  : clock, async active-high reset
//   en          : 0 blanks the display and restarts the scan
//   load        : strobe capturing hex_in/dp_in into staging
//   hex_in      : nibble k = digit k (digit 0 rightmost)
//   dp_in       : decimal point requests, active-high
//   an          : anodes, active-low one-cold
//   sseg        : {dp,g,f,e,d,c,b,a}, active-low
//   frame_done  : high during the GAP cycle where the index wraps
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_BITS = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   hex_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  output logic [N_DIGITS-1:0]     an,
  output logic [7:0]              sseg,
  output logic                    frame_done
);

  localparam int IW = idx_w(N_DIGITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  state_t                        state_q, state_d;
  logic [REFRESH_BITS-1:0]       q_q, q_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [N_DIGITS-1:0][3:0]      stage_hex_q, shadow_hex_q, shadow_hex_d;
  logic [N_DIGITS-1:0]           stage_dp_q, shadow_dp_q, shadow_dp_d;
  logic                          pending_q, pending_d;
  logic [N_DIGITS-1:0]           an_q, an_d;
  logic [7:0]                    sseg_q, sseg_d;
  logic                          fd_q, fd_d;
  logic                          commit, show;
  logic [N_DIGITS-1:0]           lit;
  logic [3:0]                    nib;
  logic [6:0]                    seg7;

  // Scan FSM next state
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    idx_d   = idx_q;
    if (!en) begin
      state_d = IDLE;
      q_d     = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SHOW;
          q_d     = '0;
          idx_d   = '0;
        end
        SHOW: begin
          q_d = q_q + 1'b1;           // wraps to 0 on the last lit cycle
          if (&q_q) state_d = GAP;
        end
        GAP: begin
          state_d = SHOW;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Shadow is only ever rewritten with pending staging data, at the wrap GAP
  // or any idle cycle. Outputs decode from the next shadow so the first slot
  // after a commit already shows the new frame.
  assign commit       = pending_q &&
                        ((state_q == IDLE) || ((state_q == GAP) && (idx_q == IDX_LAST)));
  assign shadow_hex_d = commit ? stage_hex_q : shadow_hex_q;
  assign shadow_dp_d  = commit ? stage_dp_q  : shadow_dp_q;
  // A load coinciding with a commit keeps pending set for the next boundary.
  assign pending_d    = load ? 1'b1 : (commit ? 1'b0 : pending_q);

`ifdef SSEG_LZ_BLANK_EN
  // Digit k>0 is dark when it and all higher nibbles are zero, unless its dp
  // is requested.
  always_comb begin
    logic any_nz;
    any_nz = 1'b0;
    lit    = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      any_nz = any_nz | (|shadow_hex_d[k]);
      lit[k] = (k == 0) || any_nz || shadow_dp_d[k];
    end
  end
`else
  assign lit = '1;
`endif

  assign nib = shadow_hex_d[idx_d];

  hex2sseg u_dec (
    .hex_i (nib),
    .seg_o (seg7)
  );

  assign show = (state_d == SHOW) && lit[idx_d];

  always_comb begin
    an_d = '1;
    if (show) an_d[idx_d] = 1'b0;
    sseg_d = show ? {~shadow_dp_d[idx_d], seg7} : SSEG_BLANK;
    // idx_d equals idx_q when entering GAP, so this marks the wrapping GAP.
    fd_d   = (state_d == GAP) && (idx_d == IDX_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      q_q          <= '0;
      idx_q        <= '0;
      stage_hex_q  <= '0;
      stage_dp_q   <= '0;
      shadow_hex_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      an_q         <= '1;
      sseg_q       <= SSEG_BLANK;
      fd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_q          <= q_d;
      idx_q        <= idx_d;
      shadow_hex_q <= shadow_hex_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      fd_q         <= fd_d;
      if (load) begin
        stage_hex_q <= hex_in;
        stage_dp_q  <= dp_in;
      end
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
module tb_sseg_scan_ctrl;

  localparam int N  = 4;
  localparam int RB = 2;
  localparam int P  = 1 << RB;   // lit cycles per slot
  localparam int SL = P + 1;     // slot incl. gap
  localparam int F  = N * SL;    // frame length

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [4*N-1:0] hex_in = '0;
  logic [N-1:0]  dp_in = '0;
  logic [N-1:0]  an;
  logic [7:0]    sseg;
  logic          frame_done;

  sseg_scan_ctrl #(.N_DIGITS(N), .REFRESH_BITS(RB)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .an         (an),
    .sseg       (sseg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Reference: position within a frame, not an FSM.
  bit         m_run;
  int         m_t;
  logic [15:0] m_shex, m_stage_hex;
  logic [3:0]  m_sdp, m_stage_dp;

  logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, obs, exp);
    end
  endtask

  function automatic bit m_lit(input int d);
`ifdef SSEG_LZ_BLANK_EN
    return (d == 0) || m_sdp[d] || ((m_shex >> (4 * d)) != 16'h0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_run = 0; m_t = 0;
    m_shex = '0; m_sdp = '0; m_stage_hex = '0; m_stage_dp = '0;
  endtask

  task automatic model_edge();
    if (!m_run || m_t == F - 1) begin
      m_shex = m_stage_hex;
      m_sdp  = m_stage_dp;
    end
    if (load) begin
      m_stage_hex = hex_in;
      m_stage_dp  = dp_in;
    end
    if (!en)        begin m_run = 0; m_t = 0; end
    else if (!m_run) begin m_run = 1; m_t = 0; end
    else            m_t = (m_t + 1) % F;
  endtask

  task automatic compare_outputs();
    logic [3:0] e_an;
    logic [7:0] e_sseg;
    logic       e_fd;
    int d, w;
    e_an = 4'hF; e_sseg = 8'hFF; e_fd = 1'b0;
    if (m_run) begin
      d = m_t / SL;
      w = m_t % SL;
      if (w == P) e_fd = (d == N - 1);
      else if (m_lit(d)) begin
        e_an = ~(4'b1 << d);
        e_sseg = {~m_sdp[d], SEG[(m_shex >> (4 * d)) & 16'hF]};
      end
    end
    check("an", {12'h0, an}, {12'h0, e_an});
    check("sseg", {8'h0, sseg}, {8'h0, e_sseg});
    check("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int tgt);
    int n;
    n = 0;
    while (!(m_run && m_t == tgt) && n < 3 * F) begin
      step();
      n++;
    end
    if (!(m_run && m_t == tgt)) begin
      checks++;
      errs++;
      $error("FAIL run_until timeout observed=%0d expected=%0d", m_t, tgt);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 0; load = 0;
    reset = 1;
    #1;
    model_reset();
    compare_outputs();
    check("rst_an", {12'h0, an}, 16'h000F);
    check("rst_sseg", {8'h0, sseg}, 16'h00FF);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // stage 1234 while idle, then enable
    hex_in = 16'h1234; dp_in = 4'b0000; load = 1;
    step();
    load = 0;
    step();
    en = 1;
    step();
    check("first_an", {12'h0, an}, 16'h000E);
    check("first_seg", {9'h0, sseg[6:0]}, 16'h0019);
    run(2 * F);

    // load mid-frame while digit 1 shows
    run_until(SL + 1);
    hex_in = 16'hABCD; load = 1;
    step();
    load = 0;
    run(F + 10);

    // load coincident with the commit GAP
    run_until(F - 1);
    hex_in = 16'h5678; dp_in = 4'b0101; load = 1;
    step();
    load = 0;
    run(2 * F + 5);

    // drop enable during digit 2
    run_until(2 * SL + 1);
    en = 0;
    step();
    check("en_drop_an", {12'h0, an}, 16'h000F);
    step();
    en = 1;
    run(F + 5);

    // leading-zero pattern, then dp on the top digit
    hex_in = 16'h0070; dp_in = 4'b0000; load = 1;
    step();
    load = 0;
    run(2 * F + 2);
    hex_in = 16'h0070; dp_in = 4'b1000; load = 1;
    step();
    load = 0;
    run(2 * F + 2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      load   = ($urandom % 8) == 0;
      hex_in = 16'($urandom);
      if ($urandom % 3 == 0) hex_in = hex_in & 16'h00FF;
      dp_in  = 4'($urandom);
      en     = ($urandom % 60) != 0;
      step();
    end
    load = 0; en = 1;

    // reset mid-slot loses pending data
    run_until(7);
    hex_in = 16'h9999; load = 1;
    step();
    load = 0;
    do_reset();
    en = 1;
    run(F + 3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
